// File: rtl/ransac_fixed_pkg.sv
// Shared fixed-point types and helpers for the RANSAC datapath.
// fixed_t is signed Q16.16; fma_opcode_t selects FMA operand signs.
package ransac_fixed;

  localparam int value_width = 32;
  localparam int fraction_bits = 16;

  typedef logic signed [value_width-1:0] fixed_t;

  typedef enum logic [1:0] {
    FMA_OPCODE_POS_A_POS_C = 2'd0,
    FMA_OPCODE_POS_A_NEG_C = 2'd1,
    FMA_OPCODE_NEG_A_POS_C = 2'd2,
    FMA_OPCODE_NEG_A_NEG_C = 2'd3
  } fma_opcode_t;

  function automatic int value_bits();
    return value_width;
  endfunction

  function automatic fixed_t fixed_max();
    return {1'b0, {(value_width-1){1'b1}}};
  endfunction

  // Magnitude that clamps the most negative value to fixed_max().
  function automatic fixed_t fixed_abs_sat(input fixed_t v);
    fixed_t most_neg;
    most_neg = {1'b1, {(value_width-1){1'b0}}};
    if (v == most_neg)
      return fixed_max();
    else if (v < 0)
      return -v;
    else
      return v;
  endfunction

endpackage

// File: rtl/ransac_saturating_counter.sv
// Up-counter that sticks at all-ones; clear has priority.
// Ports: clock, reset (async low), clear, increment, value.
module ransac_saturating_counter #(
  parameter int width = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             increment,
  output logic [width-1:0] value
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      value <= '0;
    else if (clear)
      value <= '0;
    else if (increment && (value != '1))
      value <= value + 1'b1;
  end

endmodule

// File: rtl/ransac_residual_sequencer.sv
// Scores a line model over a point batch via two chained FMAs.
// Ports: model/point in, FMA req/resp, inlier/point count out.
module ransac_residual_sequencer
  import ransac_fixed::*;
#(
  parameter int count_bits = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  model_valid,
  output logic                  model_ready,
  input  fixed_t                model_a,
  input  fixed_t                model_b,
  input  fixed_t                model_c,
  input  fixed_t                threshold,
  input  logic                  point_valid,
  output logic                  point_ready,
  input  fixed_t                point_x,
  input  fixed_t                point_y,
  input  logic                  point_last,
  output logic                  fma_input_valid,
  input  logic                  fma_input_ready,
  output fixed_t                fma_a,
  output fixed_t                fma_b,
  output fixed_t                fma_c,
  output fma_opcode_t           fma_opcode,
  input  logic                  fma_output_valid,
  input  fixed_t                fma_r,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [count_bits-1:0] inlier_count,
  output logic [count_bits-1:0] point_count
);

  typedef enum logic [2:0] {
    IDLE_MODEL,
    IDLE_POINT,
    ISSUE_AX,
    WAIT_AX,
    ISSUE_BY,
    WAIT_BY,
    CLASSIFY,
    REPORT
  } state_t;

  state_t state;
  fixed_t coef_a;
  fixed_t coef_b;
  fixed_t coef_c;
  fixed_t bound;
  fixed_t y_q;
  fixed_t r_q;
  logic   last_q;

  fixed_t mag;
  logic   model_xfer;
  logic   point_xfer;
  logic   classify;
  logic   inlier;

  assign model_xfer = model_valid && model_ready;
  assign point_xfer = point_valid && point_ready;
  assign classify   = (state == CLASSIFY);
  assign mag        = fixed_abs_sat(r_q);
  assign inlier     = classify && (mag <= bound);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE_MODEL;
      model_ready     <= 1'b1;
      point_ready     <= 1'b0;
      fma_input_valid <= 1'b0;
      result_valid    <= 1'b0;
      fma_a           <= '0;
      fma_b           <= '0;
      fma_c           <= '0;
      fma_opcode      <= FMA_OPCODE_POS_A_POS_C;
      coef_a          <= '0;
      coef_b          <= '0;
      coef_c          <= '0;
      bound           <= '0;
      y_q             <= '0;
      r_q             <= '0;
      last_q          <= 1'b0;
    end else begin
      unique case (state)
        IDLE_MODEL: if (model_xfer) begin
          coef_a      <= model_a;
          coef_b      <= model_b;
          coef_c      <= model_c;
          bound       <= threshold;
          model_ready <= 1'b0;
          point_ready <= 1'b1;
          state       <= IDLE_POINT;
        end
        IDLE_POINT: if (point_xfer) begin
          y_q             <= point_y;
          last_q          <= point_last;
          point_ready     <= 1'b0;
          fma_a           <= coef_a;
          fma_b           <= point_x;
          fma_c           <= coef_c;
          fma_opcode      <= FMA_OPCODE_POS_A_POS_C;
          fma_input_valid <= 1'b1;
          state           <= ISSUE_AX;
        end
        ISSUE_AX: if (fma_input_ready) begin
          fma_input_valid <= 1'b0;
          state           <= WAIT_AX;
        end
        // Partial sum a*x+c becomes the addend of b*y.
        WAIT_AX: if (fma_output_valid) begin
          fma_a           <= coef_b;
          fma_b           <= y_q;
          fma_c           <= fma_r;
          fma_opcode      <= FMA_OPCODE_POS_A_POS_C;
          fma_input_valid <= 1'b1;
          state           <= ISSUE_BY;
        end
        ISSUE_BY: if (fma_input_ready) begin
          fma_input_valid <= 1'b0;
          state           <= WAIT_BY;
        end
        WAIT_BY: if (fma_output_valid) begin
          r_q   <= fma_r;
          state <= CLASSIFY;
        end
        CLASSIFY: begin
          if (last_q) begin
            result_valid <= 1'b1;
            state        <= REPORT;
          end else begin
            point_ready <= 1'b1;
            state       <= IDLE_POINT;
          end
        end
        REPORT: if (result_ready) begin
          result_valid <= 1'b0;
          model_ready  <= 1'b1;
          state        <= IDLE_MODEL;
        end
        default: state <= IDLE_MODEL;
      endcase
    end
  end

  ransac_saturating_counter #(
    .width(count_bits)
  ) u_inliers (
    .clock(clock),
    .reset(reset),
    .clear(model_xfer),
    .increment(inlier),
    .value(inlier_count)
  );

  ransac_saturating_counter #(
    .width(count_bits)
  ) u_points (
    .clock(clock),
    .reset(reset),
    .clear(model_xfer),
    .increment(classify),
    .value(point_count)
  );

`ifndef SYNTHESIS
  a_fov_in_wait: assert property (
    @(posedge clock) disable iff (!reset)
    $rose(fma_output_valid) |->
      (state == WAIT_AX || state == WAIT_BY));

  a_thr_nonneg: assert property (
    @(posedge clock) disable iff (!reset)
    model_xfer |-> !threshold[value_width-1]);
`endif

endmodule

// File: tb/tb_ransac_residual_sequencer.sv
// Bench for ransac_residual_sequencer: 16-bit and 2-bit lanes
// in lockstep, each driving a behavioural FMA with set latency.
module tb_ransac_residual_sequencer;
  import ransac_fixed::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic   mv = 1'b0;
  fixed_t ma = '0;
  fixed_t mb = '0;
  fixed_t mc = '0;
  fixed_t mt = '0;
  logic   pv = 1'b0;
  logic   pl = 1'b0;
  fixed_t px = '0;
  fixed_t py = '0;
  logic   rr = 1'b0;

  logic        mr [2];
  logic        pr [2];
  logic        rv [2];
  logic        fiv [2];
  fixed_t      fa [2];
  fixed_t      fb [2];
  fixed_t      fc [2];
  fma_opcode_t fop [2];
  logic [15:0] ic [2];
  logic [15:0] pc [2];

  int lat_tab [64];
  bit rand_lat = 1'b0;
  int total = 0;
  int bad = 0;

  function automatic fixed_t fma_model(
    fixed_t a, fixed_t b, fixed_t c, fma_opcode_t op);
    longint p;
    longint s;
    p = (longint'(a) * longint'(b)) >>> fraction_bits;
    case (op)
      FMA_OPCODE_POS_A_NEG_C: s = p - longint'(c);
      FMA_OPCODE_NEG_A_POS_C: s = -p + longint'(c);
      FMA_OPCODE_NEG_A_NEG_C: s = -p - longint'(c);
      default:                s = p + longint'(c);
    endcase
    return fixed_t'(s);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int cb = (g == 0) ? 16 : 2;
    logic [cb-1:0] ic_l;
    logic [cb-1:0] pc_l;
    logic   busy;
    logic   ov;
    int     cnt;
    int     ops;
    int     viol_l = 0;
    fixed_t res;
    fixed_t rq;

    ransac_residual_sequencer #(.count_bits(cb)) u_dut (
      .clock(clk),
      .reset(rst_n),
      .model_valid(mv),
      .model_ready(mr[g]),
      .model_a(ma),
      .model_b(mb),
      .model_c(mc),
      .threshold(mt),
      .point_valid(pv),
      .point_ready(pr[g]),
      .point_x(px),
      .point_y(py),
      .point_last(pl),
      .fma_input_valid(fiv[g]),
      .fma_input_ready(!busy),
      .fma_a(fa[g]),
      .fma_b(fb[g]),
      .fma_c(fc[g]),
      .fma_opcode(fop[g]),
      .fma_output_valid(ov),
      .fma_r(rq),
      .result_valid(rv[g]),
      .result_ready(rr),
      .inlier_count(ic_l),
      .point_count(pc_l)
    );

    assign ic[g] = 16'(ic_l);
    assign pc[g] = 16'(pc_l);

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy <= 1'b0;
        ov   <= 1'b0;
        cnt  <= 0;
        ops  <= 0;
        res  <= '0;
        rq   <= '0;
      end else if (fiv[g] && !busy) begin
        busy <= 1'b1;
        ov   <= 1'b0;
        cnt  <= rand_lat ? lat_tab[ops % 64] : 4;
        ops  <= ops + 1;
        res  <= fma_model(fa[g], fb[g], fc[g], fop[g]);
      end else if (busy) begin
        if (cnt <= 1) begin
          busy <= 1'b0;
          ov   <= 1'b1;
          rq   <= res;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end

    always @(posedge clk)
      if (rst_n && fiv[g] && busy)
        viol_l <= viol_l + 1;
  end

  typedef struct {
    string  nm;
    fixed_t a;
    fixed_t b;
    fixed_t c;
    fixed_t t;
    int     n;
    fixed_t x [5];
    fixed_t y [5];
    int     ein;
    int     ept;
    int     ein2;
    int     ept2;
    bit     rl;
  } vec_t;

  vec_t vt [7];

  function automatic fixed_t fx(real v);
    return fixed_t'($rtoi(v * 65536.0));
  endfunction

  function automatic vec_t mk(
    string nm, real a, real b, real c, real t, int n,
    int ein, int ept, int ein2, int ept2, bit rl);
    vec_t v;
    v.nm = nm;
    v.a = fx(a);
    v.b = fx(b);
    v.c = fx(c);
    v.t = fx(t);
    v.n = n;
    for (int i = 0; i < 5; i++) begin
      v.x[i] = '0;
      v.y[i] = '0;
    end
    v.ein = ein;
    v.ept = ept;
    v.ein2 = ein2;
    v.ept2 = ept2;
    v.rl = rl;
    return v;
  endfunction

  task automatic chk(string nm, longint got, longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(int w);
    case (w)
      0:       return mr[0];
      1:       return pr[0];
      default: return rv[0];
    endcase
  endfunction

  task automatic wait_for(int w, string nm);
    int n = 0;
    while (!sig(w) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic run_batch(vec_t v, bit hold);
    rand_lat = v.rl;
    wait_for(0, {v.nm, "_model"});
    ma = v.a;
    mb = v.b;
    mc = v.c;
    mt = v.t;
    mv = 1'b1;
    tick();
    mv = 1'b0;
    for (int i = 0; i < v.n; i++) begin
      wait_for(1, {v.nm, "_point"});
      px = v.x[i];
      py = v.y[i];
      pl = (i == v.n - 1);
      pv = 1'b1;
      tick();
      pv = 1'b0;
      pl = 1'b0;
    end
    wait_for(2, {v.nm, "_result"});
    if (hold) begin
      for (int k = 0; k < 10; k++) begin
        chk({v.nm, "_hold_valid"}, rv[0], 1);
        chk({v.nm, "_hold_in"}, ic[0], v.ein);
        chk({v.nm, "_hold_pt"}, pc[0], v.ept);
        chk({v.nm, "_hold_mready"}, mr[0], 0);
        tick();
      end
    end
    chk({v.nm, "_in16"}, ic[0], v.ein);
    chk({v.nm, "_pt16"}, pc[0], v.ept);
    chk({v.nm, "_in2"}, ic[1], v.ein2);
    chk({v.nm, "_pt2"}, pc[1], v.ept2);
    rr = 1'b1;
    tick();
    rr = 1'b0;
    chk({v.nm, "_rv_drop"}, rv[0], 0);
    chk({v.nm, "_mready"}, mr[0], 1);
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, "_mready"}, mr[0], 1);
    chk({nm, "_pready"}, pr[0], 0);
    chk({nm, "_fiv"}, fiv[0], 0);
    chk({nm, "_rv"}, rv[0], 0);
    chk({nm, "_in"}, ic[0], 0);
    chk({nm, "_pt"}, pc[0], 0);
    chk({nm, "_fa"}, fa[0], 0);
    chk({nm, "_fc"}, fc[0], 0);
    chk({nm, "_op"}, fop[0], 0);
  endtask

  initial begin
    vec_t hv;
    vec_t rv2;
    int n;
    for (int i = 0; i < 64; i++)
      lat_tab[i] = $urandom_range(12, 1);

    vt[0] = mk("line", 1.0, 0.0, -2.0, 0.5, 3, 2, 3, 2, 3, 0);
    vt[0].x[0] = fx(2.0);  vt[0].y[0] = fx(5.0);
    vt[0].x[1] = fx(2.25); vt[0].y[1] = fx(0.0);
    vt[0].x[2] = fx(3.0);  vt[0].y[2] = fx(1.0);
    vt[1] = mk("diag", 1.0, -1.0, 0.0, 0.0, 2, 2, 2, 2, 2, 0);
    vt[1].x[0] = fx(1.5);  vt[1].y[0] = fx(1.5);
    vt[1].x[1] = fx(-3.0); vt[1].y[1] = fx(-3.0);
    vt[2] = mk("sat", 1.0, 0.0, 0.0, 1.0, 5, 5, 5, 3, 3, 0);
    vt[2].x[0] = fx(1.0);
    vt[2].x[1] = fx(-1.0);
    vt[2].x[2] = fx(0.5);
    vt[2].x[3] = fx(-0.5);
    vt[2].x[4] = fx(0.0);
    vt[3] = mk("mostneg_in", 0.0, 0.0, 0.0, 0.0, 1, 1, 1, 1, 1, 0);
    vt[3].c = 32'sh8000_0000;
    vt[3].t = 32'sh7FFF_FFFF;
    vt[4] = mk("mostneg_out", 0.0, 0.0, 0.0, 0.0, 1, 0, 1, 0, 1, 0);
    vt[4].c = 32'sh8000_0000;
    vt[4].t = 32'sh7FFF_FFFE;
    vt[5] = vt[0];
    vt[5].nm = "line_rand";
    vt[5].rl = 1'b1;
    vt[6] = mk("lsb", 1.0, 0.0, 0.0, 0.0, 3, 1, 3, 1, 3, 1);
    vt[6].x[0] = 32'sh0000_0001;
    vt[6].x[1] = -32'sh0000_0001;
    vt[6].x[2] = 32'sh0000_0000;

    repeat (3) tick();
    chk_reset_vals("por");
    rst_n = 1'b1;
    pv = 1'b1;
    repeat (3) tick();
    chk("idle_model_pready", pr[0], 0);
    pv = 1'b0;

    for (int i = 0; i < 7; i++)
      run_batch(vt[i], 1'b0);

    hv = mk("hold", 1.0, 1.0, 0.0, 1.0, 1, 1, 1, 1, 1, 0);
    hv.x[0] = fx(0.25);
    hv.y[0] = fx(0.5);
    run_batch(hv, 1'b1);

    ma = fx(1.0);
    mb = fx(-1.0);
    mc = fx(0.0);
    mt = fx(0.0);
    rand_lat = 1'b0;
    wait_for(0, "rst_model");
    mv = 1'b1;
    tick();
    mv = 1'b0;
    wait_for(1, "rst_point");
    px = fx(1.0);
    py = fx(1.0);
    pv = 1'b1;
    tick();
    pv = 1'b0;
    n = 0;
    while (!(fiv[0] && fa[0] == mb) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("rst_issue_by_timeout", 0, 1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    tick();
    rst_n = 1'b1;
    tick();
    rv2 = mk("after_rst", 1.0, 0.0, -2.0, 0.5, 2, 1, 2, 1, 2, 0);
    rv2.x[0] = fx(2.0); rv2.y[0] = fx(5.0);
    rv2.x[1] = fx(3.0); rv2.y[1] = fx(1.0);
    run_batch(rv2, 1'b0);

    chk("no_overlap16", g_lane[0].viol_l, 0);
    chk("no_overlap2", g_lane[1].viol_l, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
